// File: rtl/tank_sprite_pkg.sv
// Shared constants and types for the tank sprite fetch pipeline.
package tank_sprite_pkg;

  localparam int SPRITE_W   = 32;
  localparam int SPRITE_H   = 32;
  localparam int NUM_FRAMES = 8;

  // One 4-bit word per pixel, NUM_FRAMES frames stacked back to back.
  localparam int ROM_AW = $clog2(NUM_FRAMES * SPRITE_W * SPRITE_H);

  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

  // Sprite placement captured once per frame.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] dir;
  } sprite_pos_t;

endpackage

// File: rtl/eightsprite_rom.sv
// Eight-frame sprite image, 4-bit palette index per pixel, one-cycle
// synchronous read. The image is a built-in pattern generated at
// elaboration: word = addr[3:0] ^ frame_number, so the column low nibble
// xor the facing direction.
module eightsprite_rom
  import tank_sprite_pkg::*;
#(
  parameter int ADDR_W = ROM_AW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [3:0]        o_data
);

  localparam int DEPTH      = 1 << ADDR_W;
  localparam int FRAME_SIZE = DEPTH / NUM_FRAMES;

  logic [3:0]        w_image [DEPTH];
  logic [ADDR_W-1:0] r_addr;

  for (genvar g = 0; g < DEPTH; g++) begin : g_img
    assign w_image[g] = 4'(g % 16) ^ 4'(g / FRAME_SIZE);
  end

  // Registered read address: the synchronous-read stage of the ROM.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_addr <= '0;
    else       r_addr <= i_addr;
  end

  assign o_data = w_image[r_addr];

endmodule

// File: rtl/tank_sprite_fetch.sv
// Tank sprite fetch: latches position/direction at each vsync rising edge,
// decides per pixel whether the beam is inside the sprite box and looks up
// the palette index with a fixed two-cycle latency.
// Optional hit-blink feature: define TANK_SPRITE_BLINK_EN.
module tank_sprite_fetch
  import tank_sprite_pkg::*;
#(
  parameter int SPRITE_W     = tank_sprite_pkg::SPRITE_W,
  parameter int SPRITE_H     = tank_sprite_pkg::SPRITE_H,
  parameter int BLINK_FRAMES = 120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic [2:0] dir,
  input  logic       hit,
  output logic [3:0] index,
  output logic       visible,
  output logic       blinking
);

  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);
  localparam int AW = 3 + YW + XW;
  localparam logic [7:0] BLINK_RELOAD = 8'(BLINK_FRAMES);

  sprite_pos_t r_pos;
  logic        r_have_pos;
  logic        r_vs;
  logic        r_armed;
  logic        w_frame_start;

  logic [10:0]   w_x_end, w_y_end;
  logic          w_in_box;
  logic [XW-1:0] w_dx;
  logic [YW-1:0] w_dy;
  logic [AW-1:0] w_addr;
  logic          w_blink_mask;

  logic          r_inbox1, r_mask1;
  logic [3:0]    w_rom_q;
  logic [3:0]    r_index;
  logic          r_visible;

  // r_armed blocks a false edge when vs was already high across reset:
  // a frame only starts once vs has been seen low.
  assign w_frame_start = vs && !r_vs && r_armed;

  // vsync history and arming
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vs    <= 1'b0;
      r_armed <= !vs;
    end else begin
      r_vs <= vs;
      if (!vs) r_armed <= 1'b1;
    end
  end

  // Capture placement once per frame; nothing draws before the first capture.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pos      <= '0;
      r_have_pos <= 1'b0;
    end else if (w_frame_start) begin
      r_pos      <= '{x: pos_x, y: pos_y, dir: dir};
      r_have_pos <= 1'b1;
    end
  end

  // 11-bit box ends so a sprite near the right/bottom edge never wraps.
  assign w_x_end  = {1'b0, r_pos.x} + 11'(SPRITE_W);
  assign w_y_end  = {1'b0, r_pos.y} + 11'(SPRITE_H);
  assign w_in_box = r_have_pos
                 && ({1'b0, DrawX} >= {1'b0, r_pos.x}) && ({1'b0, DrawX} < w_x_end)
                 && ({1'b0, DrawY} >= {1'b0, r_pos.y}) && ({1'b0, DrawY} < w_y_end);

  // Power-of-two sprite: dir*W*H + dy*W + dx is a plain concatenation.
  assign w_dx   = XW'(DrawX - r_pos.x);
  assign w_dy   = YW'(DrawY - r_pos.y);
  assign w_addr = w_in_box ? {r_pos.dir, w_dy, w_dx} : '0;

`ifdef TANK_SPRITE_BLINK_EN
  logic [7:0] r_blink_cnt;

  // Blink counter: hit reloads (wins over a coincident frame), frames count down.
  always_ff @(posedge Clk) begin
    if (Reset)                                  r_blink_cnt <= 8'd0;
    else if (hit)                               r_blink_cnt <= BLINK_RELOAD;
    else if (w_frame_start && r_blink_cnt != 0) r_blink_cnt <= r_blink_cnt - 8'd1;
  end

  assign w_blink_mask = r_blink_cnt[3];
  assign blinking     = (r_blink_cnt != 8'd0);
`else
  logic [8:0] w_unused_blink;
  assign w_unused_blink = {hit, BLINK_RELOAD};
  assign w_blink_mask   = 1'b0;
  assign blinking       = 1'b0;
`endif

  // Stage 1: box and blink mask travel alongside the ROM address register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_inbox1 <= 1'b0;
      r_mask1  <= 1'b0;
    end else begin
      r_inbox1 <= w_in_box;
      r_mask1  <= w_blink_mask;
    end
  end

  eightsprite_rom #(.ADDR_W(AW)) u_rom (
    .i_clk  (Clk),
    .i_rst  (Reset),
    .i_addr (w_addr),
    .o_data (w_rom_q)
  );

  // Stage 2: blink hides the pixel but leaves the index visible downstream.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_index   <= TRANSPARENT_IDX;
      r_visible <= 1'b0;
    end else begin
      r_index   <= r_inbox1 ? w_rom_q : TRANSPARENT_IDX;
      r_visible <= r_inbox1 && !r_mask1 && (w_rom_q != TRANSPARENT_IDX);
    end
  end

  assign index   = r_index;
  assign visible = r_visible;

endmodule

// File: tb/tb_tank_sprite_fetch.sv
// Scoreboard bench for tank_sprite_fetch. Sprite image word = column
// low nibble xor facing direction (default 32x32 sprite).
module tb_tank_sprite_fetch;

  logic       Clk = 1'b0;
  logic       Reset, vs, hit;
  logic [9:0] DrawX, DrawY, pos_x, pos_y;
  logic [2:0] dir;
  logic [3:0] index;
  logic       visible, blinking;

  always #5 Clk = ~Clk;

  tank_sprite_fetch dut (
    .Clk(Clk), .Reset(Reset), .vs(vs), .DrawX(DrawX), .DrawY(DrawY),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .hit(hit),
    .index(index), .visible(visible), .blinking(blinking)
  );

  typedef struct {
    string      name;
    logic [3:0] idx;
    logic       vis;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic       chk_in = 1'b0;
  logic [1:0] vld_pipe = 2'b00;

  // Two-cycle tag pipe marks when a driven pixel reaches the outputs.
  always @(posedge Clk) vld_pipe <= {vld_pipe[0], chk_in};

  // Monitor: pop and compare whenever a tagged pixel emerges.
  always @(negedge Clk) begin
    if (vld_pipe[1]) begin
      exp_t e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: output with no expected entry (idx=%0d vis=%0b)", index, visible);
      end else begin
        e = sb.pop_front();
        if (index !== e.idx || visible !== e.vis) begin
          bad++;
          $display("FAIL %s: got idx=%0d vis=%0b, want idx=%0d vis=%0b",
                   e.name, index, visible, e.idx, e.vis);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pix(input string n, input int x, input int y, input int ei, input bit ev);
    exp_t e;
    DrawX  = 10'(x);
    DrawY  = 10'(y);
    chk_in = 1'b1;
    e.name = n; e.idx = 4'(ei); e.vis = ev;
    sb.push_back(e);
    tick();
    chk_in = 1'b0;
  endtask

  task automatic frame(input int px, input int py, input int d, input bit h);
    pos_x = 10'(px); pos_y = 10'(py); dir = 3'(d);
    vs = 1'b1; hit = h;
    tick();
    vs = 1'b0; hit = 1'b0;
    tick();
  endtask

  task automatic check(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", n, act, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; vs = 1'b0; hit = 1'b0;
    DrawX = '0; DrawY = '0; pos_x = '0; pos_y = '0; dir = '0;
    tick();
    check("rst_index",    int'(index),    0);
    check("rst_visible",  int'(visible),  0);
    check("rst_blinking", int'(blinking), 0);
    tick();
    Reset = 1'b0;
    tick();

    // No frame latched yet: even (5,5) inside a 0,0 box stays hidden.
    pix("pre_frame", 5, 5, 0, 0);

    // Latch 100,50 dir 0
    frame(100, 50, 0, 1'b0);
    pix("word0",      100, 50, 0, 0);
    pix("dx1",        101, 50, 1, 1);
    pix("dx15",       115, 60, 15, 1);
    pix("corner",     131, 81, 15, 1);
    pix("right_out",  132, 50, 0, 0);
    pix("left_out",    99, 50, 0, 0);
    pix("below_out",  100, 82, 0, 0);
    pix("above_out",  100, 49, 0, 0);

    // Direction 5: address 5187 -> 3 ^ 5 = 6
    frame(100, 50, 5, 1'b0);
    pix("dir5_5187",  103, 52, 6, 1);
    pix("dir5_trans", 105, 50, 0, 0);
    pix("dir5_dx10",  110, 50, 15, 1);

    // Mid-frame position change is ignored until the next vsync edge
    frame(100, 50, 0, 1'b0);
    pos_x = 10'd300;
    pix("mid_new_pos", 302, 50, 0, 0);
    pix("mid_old_pos", 101, 50, 1, 1);
    frame(300, 50, 0, 1'b0);
    pix("next_frame",  302, 50, 2, 1);

    // Right and bottom clipping, no wrap-around
    frame(620, 10, 0, 1'b0);
    pix("clip_620",   620, 10, 0, 0);
    pix("clip_639",   639, 10, 3, 1);
    pix("clip_wrap0",   0, 10, 0, 0);
    pix("clip_wrap11", 11, 10, 0, 0);
    frame(5, 470, 0, 1'b0);
    pix("clip_y479",    6, 479, 1, 1);
    pix("clip_wrap_y",  6,   0, 0, 0);

    // One-cycle reset mid-line
    frame(100, 50, 0, 1'b0);
    pix("pre_rst_a", 101, 50, 1, 1);
    pix("pre_rst_b", 102, 50, 2, 1);
    pix("rst_m1",    103, 50, 0, 0);
    Reset = 1'b1;
    pix("rst_cyc",   104, 50, 0, 0);
    Reset = 1'b0;
    pix("rst_p1",    105, 50, 0, 0);
    pix("rst_p2",    106, 50, 0, 0);
    frame(100, 50, 0, 1'b0);
    pix("post_rst_vs", 101, 50, 1, 1);

    // vs held high across reset: no frame until it falls and rises again
    idle(3);
    vs = 1'b1; Reset = 1'b1;
    tick();
    Reset = 1'b0;
    idle(2);
    pix("vs_held", 101, 50, 0, 0);
    vs = 1'b0;
    tick();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    pix("vs_rerise", 101, 50, 1, 1);
    idle(2);

`ifdef TANK_SPRITE_BLINK_EN
    hit = 1'b1;
    tick();
    hit = 1'b0;
    check("blink_on", int'(blinking), 1);
    pix("blink_hidden", 101, 50, 1, 0);
    repeat (8) frame(100, 50, 0, 1'b0);
    pix("blink_shown", 101, 50, 1, 1);
    repeat (8) frame(100, 50, 0, 1'b0);
    pix("blink_hidden2", 101, 50, 1, 0);
    repeat (103) frame(100, 50, 0, 1'b0);
    check("blink_119", int'(blinking), 1);
    frame(100, 50, 0, 1'b0);
    check("blink_120", int'(blinking), 0);
    pix("blink_done", 101, 50, 1, 1);
    // hit on a frame_start cycle reloads to the full count
    frame(100, 50, 0, 1'b1);
    repeat (119) frame(100, 50, 0, 1'b0);
    check("hitfs_119", int'(blinking), 1);
    frame(100, 50, 0, 1'b0);
    check("hitfs_120", int'(blinking), 0);
`else
    hit = 1'b1;
    tick();
    hit = 1'b0;
    check("hit_ignored_blink", int'(blinking), 0);
    pix("hit_ignored_vis", 101, 50, 1, 1);
`endif

    idle(4);
    check("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
